// File: rtl/weight_buffer_ctrl.sv
// weight_buffer_ctrl
// Sequences a bank-organised weight buffer. A load streams TN*TM words in
// bank-major order into port A. A read sweep walks port B addresses 0..TM-1
// across all banks in parallel. Loaded weights stay valid and can be swept
// repeatedly until the next load is started.
module weight_buffer_ctrl #(
   parameter int TN         = 4,
   parameter int TM         = 16,
   parameter int ADDR_WIDTH = $clog2(TM),
   parameter int ADDR_EXT   = $clog2(TN) + 1,
   parameter int DATA_WIDTH = 64
) (
   input  logic                           clk,
   input  logic                           rst_n,
   // load stream
   input  logic                           load_start,
   input  logic [DATA_WIDTH-1:0]          s_data,
   input  logic                           s_valid,
   output logic                           s_ready,
   // buffer port A (write)
   output logic                           wbuf_ena,
   output logic                           wbuf_wea,
   output logic [ADDR_EXT+ADDR_WIDTH-1:0] wbuf_addra,
   output logic [DATA_WIDTH-1:0]          wbuf_dia,
   // read sweep control
   input  logic                           rd_start,
   input  logic                           rd_hold,
   // buffer port B (read)
   output logic                           wbuf_enb,
   output logic [ADDR_WIDTH-1:0]          wbuf_addrb,
   output logic                           rd_valid,
   output logic                           rd_last,
   // status
   output logic                           loaded,
   output logic                           busy
);

   // Bank-select field of the port A address; the top address bit is a spare
   // that is always written as zero.
   localparam int BANK_W = ADDR_EXT - 1;
   localparam logic [BANK_W-1:0]     LAST_BANK = BANK_W'(TN - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_WORD = ADDR_WIDTH'(TM - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      LOADED = 2'd2,
      READ   = 2'd3
   } state_t;

   state_t state_reg, state_next;

   // Load position kept as separate bank/word counters so the bank-major
   // ordering holds even when TM is not a power of two.
   logic [BANK_W-1:0]     bank_reg, bank_next;
   logic [ADDR_WIDTH-1:0] word_reg, word_next;

   // Read sweep address.
   logic [ADDR_WIDTH-1:0] rd_cnt_reg, rd_cnt_next;

   // Registered port A write path.
   logic                           wr_en_reg;
   logic [ADDR_EXT+ADDR_WIDTH-1:0] wr_addr_reg;
   logic [DATA_WIDTH-1:0]          wr_data_reg;

   // Read-data qualifiers, aligned to the one-cycle buffer read latency.
   logic rd_valid_reg;
   logic rd_last_reg;

   // Derived strobes.
   logic in_load;
   logic in_read;
   logic beat_accept;
   logic last_beat;
   logic rd_en;
   logic rd_at_last;

   assign in_load     = (state_reg == LOAD);
   assign in_read     = (state_reg == READ);
   // s_ready is simply "in LOAD", so a handshake is s_valid while loading.
   assign beat_accept = in_load && s_valid;
   assign last_beat   = beat_accept && (bank_reg == LAST_BANK) && (word_reg == LAST_WORD);
   assign rd_en       = in_read && !rd_hold;
   assign rd_at_last  = rd_en && (rd_cnt_reg == LAST_WORD);

   // Next-state selection; rd_start wins over load_start once weights are loaded.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (load_start) begin
               state_next = LOAD;
            end
         end
         LOAD: begin
            if (last_beat) begin
               state_next = LOADED;
            end
         end
         LOADED: begin
            if (rd_start) begin
               state_next = READ;
            end else if (load_start) begin
               state_next = LOAD;
            end
         end
         READ: begin
            if (rd_at_last) begin
               state_next = LOADED;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Load counters: parked at zero outside LOAD so every load starts at bank 0, word 0.
   always_comb begin
      bank_next = bank_reg;
      word_next = word_reg;
      if (!in_load) begin
         bank_next = '0;
         word_next = '0;
      end else if (beat_accept) begin
         if (word_reg == LAST_WORD) begin
            word_next = '0;
            if (bank_reg == LAST_BANK) begin
               bank_next = '0;
            end else begin
               bank_next = bank_reg + 1'b1;
            end
         end else begin
            word_next = word_reg + 1'b1;
         end
      end
   end

   // Read address: advances only on enabled cycles and returns to zero when the sweep ends.
   always_comb begin
      rd_cnt_next = rd_cnt_reg;
      if (!in_read) begin
         rd_cnt_next = '0;
      end else if (rd_en) begin
         if (rd_cnt_reg == LAST_WORD) begin
            rd_cnt_next = '0;
         end else begin
            rd_cnt_next = rd_cnt_reg + 1'b1;
         end
      end
   end

   // State and counter registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg  <= IDLE;
         bank_reg   <= '0;
         word_reg   <= '0;
         rd_cnt_reg <= '0;
      end else begin
         state_reg  <= state_next;
         bank_reg   <= bank_next;
         word_reg   <= word_next;
         rd_cnt_reg <= rd_cnt_next;
      end
   end

   // Write path: a beat accepted this cycle is presented on port A next cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_en_reg   <= 1'b0;
         wr_addr_reg <= '0;
         wr_data_reg <= '0;
      end else begin
         wr_en_reg <= beat_accept;
         if (beat_accept) begin
            wr_addr_reg <= {1'b0, bank_reg, word_reg};
            wr_data_reg <= s_data;
         end
      end
   end

   // Read qualifiers trail the port B enable by the buffer read latency.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_valid_reg <= 1'b0;
         rd_last_reg  <= 1'b0;
      end else begin
         rd_valid_reg <= rd_en;
         rd_last_reg  <= rd_at_last;
      end
   end

   assign s_ready    = in_load;
   assign wbuf_ena   = wr_en_reg;
   assign wbuf_wea   = wr_en_reg;
   assign wbuf_addra = wr_addr_reg;
   assign wbuf_dia   = wr_data_reg;
   assign wbuf_enb   = rd_en;
   assign wbuf_addrb = rd_cnt_reg;
   assign rd_valid   = rd_valid_reg;
   assign rd_last    = rd_last_reg;
   assign loaded     = (state_reg == LOADED);
   assign busy       = in_load || in_read;

endmodule

// File: tb/tb_weight_buffer_ctrl.sv
// tb_weight_buffer_ctrl
// Randomised stimulus with a scoreboard: stimulus tasks push expected port A
// writes and port B reads into queues; a negedge monitor pops and compares
// whenever the DUT presents a write, a read enable or a read-valid.
module tb_weight_buffer_ctrl;

   localparam int TN = 4;
   localparam int TM = 16;
   localparam int AW = 4;
   localparam int AE = 3;
   localparam int DW = 64;
   localparam int NW = TN * TM;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst_n;
   logic           load_start;
   logic [DW-1:0]  s_data;
   logic           s_valid;
   logic           s_ready;
   logic           wbuf_ena;
   logic           wbuf_wea;
   logic [AE+AW-1:0] wbuf_addra;
   logic [DW-1:0]  wbuf_dia;
   logic           rd_start;
   logic           rd_hold;
   logic           wbuf_enb;
   logic [AW-1:0]  wbuf_addrb;
   logic           rd_valid;
   logic           rd_last;
   logic           loaded;
   logic           busy;

   weight_buffer_ctrl #(
      .TN(TN), .TM(TM), .ADDR_WIDTH(AW), .ADDR_EXT(AE), .DATA_WIDTH(DW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .wbuf_ena(wbuf_ena), .wbuf_wea(wbuf_wea), .wbuf_addra(wbuf_addra), .wbuf_dia(wbuf_dia),
      .rd_start(rd_start), .rd_hold(rd_hold),
      .wbuf_enb(wbuf_enb), .wbuf_addrb(wbuf_addrb), .rd_valid(rd_valid), .rd_last(rd_last),
      .loaded(loaded), .busy(busy)
   );

   // Abstract controller mode as the bench believes it to be.
   typedef enum logic [1:0] {M_IDLE, M_LOAD, M_LOADED, M_READ} mode_t;
   mode_t exp_mode = M_IDLE;

   typedef struct packed {
      logic [AE+AW-1:0] addr;
      logic [DW-1:0]    data;
   } wr_t;

   wr_t wr_q[$];
   int  enb_q[$];
   bit  last_q[$];

   int checks = 0;
   int errors = 0;
   bit mon_en = 1'b0;
   bit prev_enb = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      errors++;
      $display("FAIL %s: unexpected event at %0t", name, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: status versus expected mode, and scoreboard pops for every DUT transaction.
   always @(negedge clk) begin
      if (mon_en) begin
         check("s_ready", 64'(s_ready), 64'(exp_mode == M_LOAD));
         check("loaded", 64'(loaded), 64'(exp_mode == M_LOADED));
         check("busy", 64'(busy), 64'(exp_mode == M_LOAD || exp_mode == M_READ));
         check("ena_eq_wea", 64'(wbuf_ena), 64'(wbuf_wea));
         if (wbuf_wea) begin
            if (wr_q.size() == 0) begin
               fail_now("extra_write");
            end else begin
               wr_t e;
               e = wr_q.pop_front();
               check("addra", 64'(wbuf_addra), 64'(e.addr));
               check("dia", wbuf_dia, e.data);
               $display("write addr=%0h data=%0h", wbuf_addra, wbuf_dia);
            end
         end
         if (wbuf_enb) begin
            if (enb_q.size() == 0) begin
               fail_now("extra_enb");
            end else begin
               int a;
               a = enb_q.pop_front();
               check("addrb", 64'(wbuf_addrb), 64'(a));
               $display("read  addrb=%0d", wbuf_addrb);
            end
         end
         if (rd_valid) begin
            if (last_q.size() == 0) begin
               fail_now("extra_valid");
            end else begin
               bit l;
               l = last_q.pop_front();
               check("rd_last", 64'(rd_last), 64'(l));
            end
         end else begin
            check("rd_last_idle", 64'(rd_last), 64'(0));
         end
         check("valid_align", 64'(rd_valid), 64'(prev_enb));
         prev_enb = wbuf_enb;
      end
   end

   // Load TN*TM beats; gapped inserts idle cycles with stray ignored controls.
   // stop_at >= 0 pulls reset while presenting that beat.
   task automatic do_load(input bit gapped, input int stop_at);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      exp_mode = M_LOAD;
      for (int i = 0; i < NW; i++) begin
         if (gapped) begin
            while ($urandom_range(0, 1) == 1) begin
               s_valid    = 1'b0;
               s_data     = {$urandom, $urandom};
               rd_start   = ($urandom_range(0, 3) == 0);
               load_start = ($urandom_range(0, 3) == 0);
               rd_hold    = ($urandom_range(0, 1) == 1);
               tick();
            end
         end
         rd_start   = 1'b0;
         load_start = 1'b0;
         if (i == stop_at) begin
            rst_n   = 1'b0;
            s_valid = 1'b1;
            s_data  = {$urandom, $urandom};
            tick();
            rst_n   = 1'b1;
            s_valid = 1'b0;
            exp_mode = M_IDLE;
            return;
         end
         begin
            wr_t e;
            s_valid = 1'b1;
            s_data  = {$urandom, $urandom};
            e.addr  = {1'b0, 2'(i / TM), 4'(i % TM)};
            e.data  = s_data;
            wr_q.push_back(e);
         end
         tick();
      end
      s_valid  = 1'b0;
      rd_hold  = 1'b0;
      exp_mode = M_LOADED;
   endtask

   // One read sweep; hold_at >= 0 stalls at that address for hold_len cycles,
   // otherwise stalls are random. with_load raises load_start alongside rd_start.
   task automatic do_read(input int hold_at, input int hold_len, input bit with_load);
      int rd;
      int held;
      int guard;
      bit hold;
      rd_start   = 1'b1;
      load_start = with_load;
      tick();
      exp_mode = M_READ;
      for (int a = 0; a < TM; a++) begin
         enb_q.push_back(a);
         last_q.push_back(a == TM - 1);
      end
      rd = 0;
      held = 0;
      guard = 0;
      while (rd < TM) begin
         hold = (rd == hold_at && held < hold_len) ||
                (hold_at < 0 && $urandom_range(0, 7) == 0);
         rd_hold    = hold;
         rd_start   = ($urandom_range(0, 3) == 0);
         load_start = ($urandom_range(0, 3) == 0);
         s_valid    = ($urandom_range(0, 1) == 1);
         @(negedge clk);
         check("enb_vs_hold", 64'(wbuf_enb), 64'(!hold));
         check("addrb_track", 64'(wbuf_addrb), 64'(rd));
         tick();
         if (hold) held++;
         else      rd++;
         guard++;
         if (guard > 1000) begin
            fail_now("read_timeout");
            break;
         end
      end
      rd_hold    = 1'b0;
      rd_start   = 1'b0;
      load_start = 1'b0;
      s_valid    = 1'b0;
      exp_mode   = M_LOADED;
      check("addrb_wrap", 64'(wbuf_addrb), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      load_start = 1'b0;
      s_data     = '0;
      s_valid    = 1'b0;
      rd_start   = 1'b0;
      rd_hold    = 1'b0;

      // Reset for two cycles, then every output must be zero.
      tick();
      tick();
      exp_mode = M_IDLE;
      check("rst_ena", 64'(wbuf_ena), 64'(0));
      check("rst_wea", 64'(wbuf_wea), 64'(0));
      check("rst_addra", 64'(wbuf_addra), 64'(0));
      check("rst_dia", wbuf_dia, 64'(0));
      check("rst_enb", 64'(wbuf_enb), 64'(0));
      check("rst_addrb", 64'(wbuf_addrb), 64'(0));
      check("rst_rd_valid", 64'(rd_valid), 64'(0));
      check("rst_rd_last", 64'(rd_last), 64'(0));
      check("rst_loaded", 64'(loaded), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_s_ready", 64'(s_ready), 64'(0));
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // s_valid in IDLE is not consumed; stray rd_start/rd_hold ignored.
      s_valid  = 1'b1;
      rd_start = 1'b1;
      rd_hold  = 1'b1;
      repeat (3) tick();
      s_valid  = 1'b0;
      rd_start = 1'b0;
      rd_hold  = 1'b0;

      // Full back-to-back load.
      do_load(1'b0, -1);
      tick();
      check("wr_drain_full", 64'(wr_q.size()), 64'(0));

      // s_valid in LOADED is not consumed.
      s_valid = 1'b1;
      repeat (3) tick();
      s_valid = 1'b0;

      // Sweep with a 3-cycle stall at address 5, then back-to-back sweeps.
      do_read(5, 3, 1'b0);
      do_read(-1, 0, 1'b0);
      // rd_start and load_start together: the read wins.
      do_read(-1, 0, 1'b1);
      tick();
      check("rd_drain_1", 64'(enb_q.size() + last_q.size()), 64'(0));

      // Gapped reload from LOADED.
      do_load(1'b1, -1);
      tick();
      check("wr_drain_gapped", 64'(wr_q.size()), 64'(0));

      for (int k = 0; k < 3; k++) begin
         do_read($urandom_range(0, TM - 1), $urandom_range(1, 4), 1'b0);
      end
      tick();
      check("rd_drain_2", 64'(enb_q.size() + last_q.size()), 64'(0));

      // Reset while beat 30 is presented: beats 0..29 are written, then IDLE.
      do_load(1'b0, 30);
      check("mid_reset_loaded", 64'(loaded), 64'(0));
      rd_start = 1'b1;
      tick();
      rd_start = 1'b0;
      repeat (4) tick();
      check("wr_drain_reset", 64'(wr_q.size()), 64'(0));
      check("rd_drain_reset", 64'(enb_q.size() + last_q.size()), 64'(0));

      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
